// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester's handshake and load/store bus into the data-memory arbiter
interface dmem_port_arbiter_if #(parameter int AW = 32);
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          done;
  modport master(output req, we, be, addr, wdata, input gnt, done);
  modport slave(input req, we, be, addr, wdata, output gnt, done);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port word memory between two requesters,
// turning partial-byte stores into a read-modify-write
module dmem_port_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int AW         = 32
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave p0,
  dmem_port_arbiter_if.slave p1,
  output logic [31:0]        rdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_A,
  output logic [31:0]        mem_WD,
  input  logic [31:0]        mem_RD
);
  typedef enum logic [1:0] {IDLE, ACC, WR} state_t;
  state_t state, next;
  logic owner, last, win, take, we_q, done_q, partial;
  logic [3:0] be_q;
  logic [31:0] merged;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    take = p0.req | p1.req;
    win = (p0.req & p1.req) ? (FIXED_PRIO ? 1'b0 : ~last) : p1.req;
    partial = we_q & (be_q != 4'h0) & (be_q != 4'hF);
    next = state == IDLE ? (take ? ACC : IDLE) : (state == ACC && partial) ? WR : IDLE;
    mem_we = state == WR || (state == ACC && we_q && be_q == 4'hF);
    p0.gnt = state == ACC && !owner;
    p1.gnt = state == ACC && owner;
    p0.done = done_q & ~owner;
    p1.done = done_q & owner;
    for (int i = 0; i < 4; i++) merged[8*i+:8] = be_q[i] ? mem_WD[8*i+:8] : mem_RD[8*i+:8];
  end
  // last=1 after reset so a contended first grant goes to port 0; mem_WD doubles as the latched store data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner  <= 1'b0;
      last   <= 1'b1;
      we_q   <= 1'b0;
      be_q   <= 4'h0;
      done_q <= 1'b0;
      rdata  <= '0;
      mem_A  <= '0;
      mem_WD <= '0;
    end else begin
      done_q <= (state == ACC && !partial) || state == WR;
      if (state == IDLE && take) begin
        owner  <= win;
        last   <= win;
        we_q   <= win ? p1.we : p0.we;
        be_q   <= win ? p1.be : p0.be;
        mem_A  <= (win ? p1.addr : p0.addr) & ~AW'(3);
        mem_WD <= win ? p1.wdata : p0.wdata;
      end
      if (state == ACC && !we_q) rdata <= mem_RD;
      if (state == ACC && partial) mem_WD <= merged;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vectors, multi-cycle corner sequences and
// randomized two-port traffic against a transaction-level memory model
module tb_dmem_port_arbiter;
  typedef struct packed {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} op_t;
  typedef struct {int port; op_t op; logic [31:0] init; logic [31:0] exp; int lat; int wes;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_port_arbiter_if ia0(), ia1(), ib0(), ib1();
  logic [31:0] rd_rr, rd_fp, wd_rr, wd_fp, md_rr, md_fp, a_rr, a_fp;
  logic we_rr, we_fp;
  logic [1:0] g_rr, d_rr, g_fp, d_fp;
  logic [31:0] mem_rr [16];
  logic [31:0] mem_fp [16];
  logic [31:0] refm [16];
  logic pk = 1'b0;
  logic [3:0] pa = 4'h0;
  logic [31:0] pd = 32'h0;
  logic [31:0] last_ld;
  op_t qs [2][$];
  int tests = 0, fails = 0;
  assign ib0.req = ia0.req;
  assign ib0.we = ia0.we;
  assign ib0.be = ia0.be;
  assign ib0.addr = ia0.addr;
  assign ib0.wdata = ia0.wdata;
  assign ib1.req = ia1.req;
  assign ib1.we = ia1.we;
  assign ib1.be = ia1.be;
  assign ib1.addr = ia1.addr;
  assign ib1.wdata = ia1.wdata;
  assign g_rr = {ia1.gnt, ia0.gnt};
  assign d_rr = {ia1.done, ia0.done};
  assign g_fp = {ib1.gnt, ib0.gnt};
  assign d_fp = {ib1.done, ib0.done};
  assign md_rr = mem_rr[a_rr[5:2]];
  assign md_fp = mem_fp[a_fp[5:2]];
  always @(posedge clk) begin
    if (we_rr) mem_rr[a_rr[5:2]] <= wd_rr;
    if (pk) mem_rr[pa] <= pd;
    if (we_fp) mem_fp[a_fp[5:2]] <= wd_fp;
  end
  dmem_port_arbiter #(.FIXED_PRIO(1'b0), .AW(32)) u_rr (
    .clk(clk), .rst(rst), .p0(ia0.slave), .p1(ia1.slave), .rdata(rd_rr),
    .mem_we(we_rr), .mem_A(a_rr), .mem_WD(wd_rr), .mem_RD(md_rr));
  dmem_port_arbiter #(.FIXED_PRIO(1'b1), .AW(32)) u_fp (
    .clk(clk), .rst(rst), .p0(ib0.slave), .p1(ib1.slave), .rdata(rd_fp),
    .mem_we(we_fp), .mem_A(a_fp), .mem_WD(wd_fp), .mem_RD(md_fp));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input int p, input logic r, input op_t o);
    if (p == 0) begin
      ia0.req = r; ia0.we = o.we; ia0.be = o.be; ia0.addr = o.addr; ia0.wdata = o.wdata;
    end else begin
      ia1.req = r; ia1.we = o.we; ia1.be = o.be; ia1.addr = o.addr; ia1.wdata = o.wdata;
    end
  endtask
  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    pk = 1'b1; pa = a; pd = d;
    @(negedge clk);
    pk = 1'b0;
  endtask
  task automatic do_reset();
    drive(0, 1'b0, op_t'(0));
    drive(1, 1'b0, op_t'(0));
    rst = 1'b0;
    #1;
    chk("reset_ctl", 64'({g_rr, d_rr, g_fp, d_fp, we_rr, we_fp}), 64'(0));
    chk("reset_data", 64'({rd_rr, a_rr}) | 64'(wd_rr), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v [7];
    v[0] = '{0, '{1'b0, 4'h0, 32'h10, 32'h0},        32'hDEADBEEF, 32'hDEADBEEF, 2, 0};
    v[1] = '{1, '{1'b1, 4'h2, 32'h14, 32'h0000AB00}, 32'h11223344, 32'h1122AB44, 3, 1};
    v[2] = '{0, '{1'b1, 4'hF, 32'h23, 32'hCAFEF00D}, 32'h55555555, 32'hCAFEF00D, 2, 1};
    v[3] = '{0, '{1'b1, 4'h0, 32'h24, 32'hFFFFFFFF}, 32'h0BADF00D, 32'h0BADF00D, 2, 0};
    v[4] = '{1, '{1'b0, 4'h0, 32'h3C, 32'h0},        32'h12345678, 32'h12345678, 2, 0};
    v[5] = '{0, '{1'b1, 4'h9, 32'h08, 32'hAABBCCDD}, 32'h11223344, 32'hAA2233DD, 3, 1};
    v[6] = '{1, '{1'b1, 4'h6, 32'h0C, 32'hAABBCCDD}, 32'h00000000, 32'h00BBCC00, 3, 1};
    #2;
    do_reset();
    last_ld = 32'h0;
    for (int j = 0; j < 7; j++) begin
      int i, gi, wes;
      bit oth, got;
      logic [31:0] rd;
      poke(v[j].op.addr[5:2], v[j].init);
      drive(v[j].port, 1'b1, v[j].op);
      i = 0; gi = 0; wes = 0; oth = 1'b0; got = 1'b0; rd = 32'h0;
      while (!got && i < 8) begin
        @(negedge clk);
        i++;
        if (we_rr) wes++;
        if (g_rr[1-v[j].port] || d_rr[1-v[j].port]) oth = 1'b1;
        if (g_rr[v[j].port]) begin
          gi = i;
          drive(v[j].port, 1'b0, v[j].op);
        end
        if (d_rr[v[j].port]) begin
          got = 1'b1;
          rd = rd_rr;
        end
      end
      chk("vec_gnt_cycle", 64'(gi), 64'(1));
      chk("vec_done_cycle", 64'(i), 64'(v[j].lat));
      chk("vec_we_pulses", 64'(wes), 64'(v[j].wes));
      chk("vec_other_port_quiet", 64'(oth), 64'(0));
      if (v[j].op.we) begin
        chk("vec_word", 64'(mem_rr[v[j].op.addr[5:2]]), 64'(v[j].exp));
        chk("vec_rdata_hold", 64'(rd), 64'(last_ld));
      end else begin
        chk("vec_rdata", 64'(rd), 64'(v[j].exp));
        last_ld = v[j].exp;
      end
    end
    // contention with both requests held high: alternating vs port-0-only
    do_reset();
    drive(0, 1'b1, '{1'b0, 4'h0, 32'h0, 32'h0});
    drive(1, 1'b1, '{1'b0, 4'h0, 32'h4, 32'h0});
    begin
      int ord[$];
      int n0, n1, seen;
      n0 = 0; n1 = 0; seen = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (g_rr[0]) ord.push_back(0);
        if (g_rr[1]) ord.push_back(1);
        n0 += int'(g_fp[0]);
        n1 += int'(g_fp[1]);
      end
      chk("rr_grant_count", 64'(ord.size()), 64'(4));
      for (int k = 0; k < 4 && k < ord.size(); k++) chk("rr_grant_order", 64'(ord[k]), 64'(k % 2));
      chk("fp_port0_grants", 64'(n0), 64'(4));
      chk("fp_port1_starved", 64'(n1), 64'(0));
      drive(0, 1'b0, op_t'(0));
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (g_fp[1] && seen == 0) begin
          seen = k;
          drive(1, 1'b0, op_t'(0));
        end
      end
      chk("fp_port1_after_drop", 64'(seen), 64'(1));
    end
    // reset in the write cycle of a read-modify-write
    do_reset();
    poke(4'd5, 32'h11111111);
    drive(0, 1'b1, '{1'b1, 4'h3, 32'h14, 32'hFFFFFFFF});
    @(negedge clk);
    chk("rmw_gnt", 64'(g_rr), 64'(2'b01));
    drive(0, 1'b0, op_t'(0));
    @(negedge clk);
    chk("rmw_wr_cycle", 64'({we_rr, wd_rr}), 64'({1'b1, 32'h1111FFFF}));
    rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'({we_rr, g_rr, d_rr, a_rr}) | 64'(rd_rr) | 64'(wd_rr), 64'(0));
    @(negedge clk);
    chk("rst_word_unchanged", 64'(mem_rr[5]), 64'(32'h11111111));
    drive(0, 1'b1, '{1'b0, 4'h0, 32'h0, 32'h0});
    drive(1, 1'b1, '{1'b0, 4'h0, 32'h4, 32'h0});
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_first_grant", 64'(g_rr), 64'(2'b01));
    drive(0, 1'b0, op_t'(0));
    drive(1, 1'b0, op_t'(0));
    @(negedge clk);
    @(negedge clk);
    // port 0 arrives while port 1 is being served
    do_reset();
    poke(4'd12, 32'hA1A1A1A1);
    poke(4'd13, 32'hB2B2B2B2);
    drive(1, 1'b1, '{1'b0, 4'h0, 32'h30, 32'h0});
    @(negedge clk);
    chk("t6_gnt1", 64'(g_rr), 64'(2'b10));
    drive(1, 1'b0, op_t'(0));
    drive(0, 1'b1, '{1'b0, 4'h0, 32'h34, 32'h0});
    @(negedge clk);
    chk("t6_done1", 64'({d_rr, g_rr, rd_rr}), 64'({2'b10, 2'b00, 32'hA1A1A1A1}));
    @(negedge clk);
    chk("t6_gnt0_rdata_hold", 64'({g_rr, rd_rr}), 64'({2'b01, 32'hA1A1A1A1}));
    drive(0, 1'b0, op_t'(0));
    @(negedge clk);
    chk("t6_done0", 64'({d_rr, rd_rr}), 64'({2'b01, 32'hB2B2B2B2}));
    // randomized traffic against a transaction-level model
    do_reset();
    last_ld = 32'h0;
    for (int w = 0; w < 16; w++) begin
      refm[w] = $urandom;
      poke(4'(w), refm[w]);
    end
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 40; j++) begin
        op_t o;
        int k;
        k = $urandom_range(0, 3);
        o.we = 1'($urandom);
        o.be = k == 0 ? 4'h0 : k == 1 ? 4'hF : 4'($urandom);
        o.addr = 32'($urandom_range(0, 63));
        o.wdata = $urandom;
        qs[p].push_back(o);
      end
    begin
      bit pres [2];
      bit ev, el;
      int ep, ec, lastw, w;
      logic [31:0] erd;
      logic [1:0] rq, eg, ed;
      pres[0] = 1'b0; pres[1] = 1'b0;
      ev = 1'b0; el = 1'b0; ep = 0; ec = 0; lastw = 1; rq = 2'b00; erd = 32'h0;
      for (int n = 0; n < 4000 && (qs[0].size() > 0 || qs[1].size() > 0 || ev); n++) begin
        @(negedge clk);
        w = (rq == 2'b11) ? 1 - lastw : (rq[1] ? 1 : 0);
        eg = (!ev && rq != 2'b00) ? 2'(1 << w) : 2'b00;
        ed = (ev && ec == n) ? 2'(1 << ep) : 2'b00;
        if (d_rr != 2'b00 || ed != 2'b00)
          chk("rand_done", 64'({d_rr, rd_rr}), 64'({ed, (ed != 2'b00 && el) ? erd : last_ld}));
        if (ed != 2'b00) begin
          if (el) last_ld = erd;
          ev = 1'b0;
        end
        if (g_rr != 2'b00 || eg != 2'b00) chk("rand_gnt", 64'(g_rr), 64'(eg));
        if (eg != 2'b00) begin
          op_t o;
          o = qs[w].pop_front();
          pres[w] = 1'b0;
          lastw = w;
          ev = 1'b1;
          ep = w;
          el = !o.we;
          ec = n + ((o.we && o.be != 4'h0 && o.be != 4'hF) ? 2 : 1);
          if (!o.we) erd = refm[o.addr[5:2]];
          else for (int b = 0; b < 4; b++) if (o.be[b]) refm[o.addr[5:2]][8*b+:8] = o.wdata[8*b+:8];
        end
        for (int p = 0; p < 2; p++) begin
          if (!pres[p] && qs[p].size() > 0 && $urandom_range(0, 2) != 0) pres[p] = 1'b1;
          drive(p, pres[p], pres[p] ? qs[p][0] : op_t'(0));
        end
        rq = {pres[1], pres[0]};
      end
      chk("rand_drain", 64'(qs[0].size() + qs[1].size()) | 64'(ev), 64'(0));
    end
    drive(0, 1'b0, op_t'(0));
    drive(1, 1'b0, op_t'(0));
    @(negedge clk);
    for (int w = 0; w < 16; w++) chk("rand_mem", 64'(mem_rr[w]), 64'(refm[w]));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
